// File: rtl/wrap_event_monitor.sv
// Epoch extension, compare-match detection and timestamped event FIFO for the 4-bit wrap counter.
// Optional counter sequence checker enabled by defining WRAP_MON_SEQ_CHECK_EN.
module wrap_event_monitor #(
  parameter int unsigned EPOCH_W    = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [3:0]                    cnt_in,
  input  logic                          ovf_in,
  input  logic                          match_en,
  input  logic [3:0]                    match_val,
  output logic                          evt_valid,
  input  logic                          evt_ready,
  output logic [EPOCH_W+5:0]            evt_data,
  output logic [EPOCH_W-1:0]            epoch,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [7:0]                    drop_cnt,
  output logic                          seq_err
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned LW = AW + 1;
  localparam int unsigned DW = EPOCH_W + 6;

  logic [DW-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          match_hit;
  logic          hit;
  logic          full;
  logic          pop;
  logic          push;
  logic          drop;
  logic [DW-1:0] evt_word;

  // Event formation uses the epoch value before this cycle's increment
  assign match_hit = match_en && (cnt_in == match_val);
  assign hit       = ovf_in || match_hit;
  assign evt_word  = {ovf_in, match_hit, epoch, cnt_in};
  assign full      = (fifo_level == LW'(FIFO_DEPTH));
  assign pop       = evt_valid && evt_ready;
  assign push      = hit && (!full || pop);
  assign drop      = hit && !push;

  assign evt_valid = (fifo_level != '0);
  assign evt_data  = evt_valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= evt_word;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LW'(1);
        2'b01:   fifo_level <= fifo_level - LW'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

  // Epoch advances on every overflow, whether or not its event was queued
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      epoch    <= '0;
      drop_cnt <= '0;
    end else begin
      if (ovf_in) epoch <= epoch + EPOCH_W'(1);
      if (drop && (drop_cnt != 8'hFF)) drop_cnt <= drop_cnt + 8'd1;
    end
  end

`ifdef WRAP_MON_SEQ_CHECK_EN
  logic [3:0] prev_cnt;
  logic       prev_valid;
  logic       seq_bad;

  assign seq_bad = prev_valid &&
                   ((cnt_in != 4'(prev_cnt + 4'd1)) || (ovf_in != (prev_cnt == 4'd15)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_cnt   <= '0;
      prev_valid <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      prev_cnt   <= cnt_in;
      prev_valid <= 1'b1;
      if (seq_bad) seq_err <= 1'b1;
    end
  end
`else
  assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_wrap_event_monitor.sv
// Self-checking bench for wrap_event_monitor: directed scenarios plus randomized traffic
// against a queue-based reference model (seq_err modelled when WRAP_MON_SEQ_CHECK_EN is defined).
module tb_wrap_event_monitor;

  localparam int unsigned EW    = 8;
  localparam int unsigned DEPTH = 4;

  logic            clk = 1'b0;
  logic            reset;
  logic [3:0]      cnt_in;
  logic            ovf_in;
  logic            match_en;
  logic [3:0]      match_val;
  logic            evt_valid;
  logic            evt_ready;
  logic [EW+5:0]   evt_data;
  logic [EW-1:0]   epoch;
  logic [2:0]      fifo_level;
  logic [7:0]      drop_cnt;
  logic            seq_err;

  wrap_event_monitor #(.EPOCH_W(EW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .cnt_in(cnt_in), .ovf_in(ovf_in),
    .match_en(match_en), .match_val(match_val), .evt_valid(evt_valid),
    .evt_ready(evt_ready), .evt_data(evt_data), .epoch(epoch),
    .fifo_level(fifo_level), .drop_cnt(drop_cnt), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [EW+5:0] q[$];
  int            m_epoch;
  int            m_drop;
  bit            m_seq;
  bit            m_prev_valid;
  int            m_prev;
  logic [3:0]    c;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [EW+5:0] head;
    head = (q.size() > 0) ? q[0] : '0;
    check({tag, ".evt_valid"},  32'(evt_valid),  32'(q.size() > 0));
    check({tag, ".evt_data"},   32'(evt_data),   32'(head));
    check({tag, ".epoch"},      32'(epoch),      32'(m_epoch));
    check({tag, ".fifo_level"}, 32'(fifo_level), 32'(q.size()));
    check({tag, ".drop_cnt"},   32'(drop_cnt),   32'(m_drop));
    check({tag, ".seq_err"},    32'(seq_err),    32'(m_seq));
  endtask

  task automatic model_clear();
    q.delete();
    m_epoch = 0;
    m_drop = 0;
    m_seq = 1'b0;
    m_prev_valid = 1'b0;
    m_prev = 0;
  endtask

  // Called at a negedge: asserts reset, checks the asynchronous clear, releases at the next negedge
  task automatic do_reset(input string tag);
    reset = 1'b1;
    #1;
    model_clear();
    check_all(tag);
    @(negedge clk);
    reset = 1'b0;
    c = 4'd0;
  endtask

  // One clock cycle: drive at negedge, advance model at posedge, check at following negedge
  task automatic cyc(input logic [3:0] cv, input logic o, input logic me,
                     input logic [3:0] mv, input logic rdy, input string tag);
    bit            pop;
    bit            mh;
    logic [EW+5:0] word;
    cnt_in = cv; ovf_in = o; match_en = me; match_val = mv; evt_ready = rdy;
    pop  = (q.size() > 0) && rdy;
    mh   = me && (cv == mv);
    word = {o, mh, EW'(m_epoch), cv};
    @(posedge clk);
    if (pop) void'(q.pop_front());
    if (o || mh) begin
      if (q.size() < DEPTH) q.push_back(word);
      else if (m_drop < 255) m_drop++;
    end
    if (o) m_epoch = (m_epoch + 1) % (1 << EW);
`ifdef WRAP_MON_SEQ_CHECK_EN
    if (m_prev_valid && ((int'(cv) != (m_prev + 1) % 16) || (o != (m_prev == 15)))) m_seq = 1'b1;
`endif
    m_prev = int'(cv);
    m_prev_valid = 1'b1;
    @(negedge clk);
    check_all(tag);
  endtask

  // Free-running counter with overflow on value 0
  task automatic run(input int n, input logic me, input logic [3:0] mv, input logic rdy,
                     input string tag);
    for (int i = 0; i < n; i++) begin
      cyc(c, c == 4'd0, me, mv, rdy, tag);
      c = c + 4'd1;
    end
  endtask

  initial begin
    reset = 1'b1; cnt_in = '0; ovf_in = 1'b0; match_en = 1'b0; match_val = '0; evt_ready = 1'b0;
    c = 4'd0;
    model_clear();
    @(negedge clk);
    check_all("reset_init");
    @(negedge clk);
    reset = 1'b0;

    // Three counter periods, overflow events only
    run(48, 1'b0, 4'd0, 1'b1, "free_run");
    check("free_run.epoch3", 32'(epoch), 32'd3);

    // Both hits on a wrap collapse to one event
    run(16, 1'b1, 4'd0, 1'b1, "dual_hit");

    // Stall the consumer: FIFO fills, further hits drop
    run(96, 1'b1, 4'd5, 1'b0, "stall");
    check("stall.full", 32'(fifo_level), 32'd4);
    run(5, 1'b1, 4'd5, 1'b0, "refill");
    // Hit while full with a simultaneous pop: accepted, level stays at depth
    cyc(c, 1'b0, 1'b1, 4'd5, 1'b1, "full_pop_push");
    check("full_pop_push.level", 32'(fifo_level), 32'd4);
    c = c + 4'd1;
    run(20, 1'b1, 4'd5, 1'b1, "drain");

    // Counter jump 3 -> 7
    do_reset("reset_seq");
    run(4, 1'b0, 4'd0, 1'b1, "seq_pre");
    c = 4'd7;
    run(10, 1'b0, 4'd0, 1'b1, "seq_jump");
`ifdef WRAP_MON_SEQ_CHECK_EN
    check("seq_jump.sticky", 32'(seq_err), 32'd1);
`else
    check("seq_jump.tied", 32'(seq_err), 32'd0);
`endif

    // Reset with three events queued
    do_reset("reset_pre_q");
    run(48, 1'b0, 4'd0, 1'b0, "queue3");
    check("queue3.level", 32'(fifo_level), 32'd3);
    do_reset("reset_mid");
    run(2, 1'b0, 4'd0, 1'b0, "post_reset");
    check("post_reset.epoch0", 32'(evt_data), 32'h2000);
    run(16, 1'b0, 4'd0, 1'b1, "post_drain");

    // Drop counter saturation and epoch wrap with back-to-back overflows
    do_reset("reset_sat");
    for (int i = 0; i < 300; i++) cyc(4'd0, 1'b1, 1'b0, 4'd0, 1'b0, "saturate");
    check("saturate.drop255", 32'(drop_cnt), 32'd255);
    for (int i = 0; i < 10; i++) cyc(4'd0, 1'b1, 1'b0, 4'd0, 1'b1, "stream");

    // Randomized traffic
    do_reset("reset_rand");
    for (int i = 0; i < 3000; i++) begin
      logic o;
      if ($urandom_range(0, 999) == 0) do_reset("rand_reset");
      if ($urandom_range(0, 49) == 0) c = 4'($urandom_range(0, 15));
      o = (c == 4'd0);
      if ($urandom_range(0, 63) == 0) o = ~o;
      cyc(c, o, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          1'($urandom_range(0, 3) != 0), "random");
      c = c + 4'd1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
